// File: rtl/sobel_edge_pkg.sv
// Shared constants for the Sobel edge stage: default widths, line-buffer depth,
// pipeline latency and the magnitude saturation limit.
package sobel_edge_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned WIDTH_W_DEF   = 12;
  localparam int unsigned MAX_WIDTH_DEF = 1024;

  // Accepting edge of the gating pixel to dout_valid, in clk cycles.
  localparam int unsigned SOBEL_LAT = 3;

  // Gradient magnitude clamps here before the threshold compare.
  localparam logic [7:0] SAT_LIMIT = 8'hFF;

endpackage

// File: rtl/sobel_linebuf.sv
// Two cascaded single-clock line buffers addressed by the pixel column.
// row1 is the pixel one line above din, row0 the pixel two lines above.
// Reads are combinational so the taps line up with din; the write on an
// accepted pixel stores din into the first RAM and the old first-RAM word into
// the second (read-before-write). The RAM contents are never reset.
module sobel_linebuf #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned AW        = $clog2(MAX_WIDTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] row1,
  output logic [DATA_W-1:0] row0
);

  logic [DATA_W-1:0] ram1 [MAX_WIDTH];
  logic [DATA_W-1:0] ram0 [MAX_WIDTH];

  // Combinational read of both rows at the current column.
  always_comb begin
    row1 = ram1[addr];
    row0 = ram0[addr];
  end

  // Shift the column down one line on every accepted pixel.
  always_ff @(posedge clk) begin
    if (we) begin
      ram1[addr] <= din;
      ram0[addr] <= ram1[addr];
    end
  end

endmodule

// File: rtl/sobel_edge.sv
// Sobel edge detector: 3x3 window from two line buffers, |Gx|+|Gy| saturated
// to 8 bits and thresholded into an edge map.
// Optional build macro SOBEL_MAG_OUT_EN: emit the saturated magnitude for edge
// pixels instead of 8'hFF. Ports and timing are the same in both builds.
import sobel_edge_pkg::*;

module sobel_edge #(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned WIDTH_W   = WIDTH_W_DEF,
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic [DATA_W-1:0]  din,
  input  logic [WIDTH_W-1:0] img_width,
  input  logic [DATA_W-1:0]  threshold,
  output logic               dout_valid,
  output logic [DATA_W-1:0]  dout
);

  localparam int unsigned AW = $clog2(MAX_WIDTH);
  localparam int unsigned GW = DATA_W + 3;

  logic [WIDTH_W-1:0] pixel_cnt, line_cnt, width_q, width_cur;
  logic               frame_start, gate;
  logic [DATA_W-1:0]  row1, row0;

  logic               acc_q, gate_q;
  logic [DATA_W-1:0]  pix_q, r1_q, r0_q;

  logic [DATA_W-1:0]  win [3][3];
  logic               v1, v2;

  logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GW-1:0] gx_q, gy_q;
  logic [GW-1:0]        ax, ay, mag;
  logic [DATA_W-1:0]    mag_sat;
  logic                 edge_hit;

  sobel_linebuf #(
    .DATA_W    (DATA_W),
    .MAX_WIDTH (MAX_WIDTH),
    .AW        (AW)
  ) u_linebuf (
    .clk  (clk),
    .we   (din_valid),
    .addr (pixel_cnt[AW-1:0]),
    .din  (din),
    .row1 (row1),
    .row0 (row0)
  );

  // Frame width in force for this pixel and the output gate for it.
  // The width_cur>=3 term keeps widths 0..2 silent even though counters wrap.
  always_comb begin
    frame_start = (pixel_cnt == '0) && (line_cnt == '0);
    width_cur   = frame_start ? img_width : width_q;
    gate        = (line_cnt >= WIDTH_W'(2)) && (pixel_cnt >= WIDTH_W'(2)) &&
                  (width_cur >= WIDTH_W'(3));
  end

  // Column/line counters over accepted pixels; width latched at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_cnt <= '0;
      line_cnt  <= '0;
      width_q   <= '0;
    end else if (din_valid) begin
      if (frame_start) width_q <= img_width;
      if (pixel_cnt == width_cur - WIDTH_W'(1)) begin
        pixel_cnt <= '0;
        line_cnt  <= (line_cnt == width_cur - WIDTH_W'(1)) ? '0 : line_cnt + WIDTH_W'(1);
      end else begin
        pixel_cnt <= pixel_cnt + WIDTH_W'(1);
      end
    end
  end

  // Capture the accepted pixel with its line-buffer taps and gate decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 1'b0;
      gate_q <= 1'b0;
      pix_q  <= '0;
      r1_q   <= '0;
      r0_q   <= '0;
    end else begin
      acc_q  <= din_valid;
      gate_q <= din_valid & gate;
      if (din_valid) begin
        pix_q <= din;
        r1_q  <= row1;
        r0_q  <= row0;
      end
    end
  end

  // S1: shift the 3x3 window left; column 2 takes the newest column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      v1 <= acc_q & gate_q;
      if (acc_q) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= r0_q;
        win[1][2] <= r1_q;
        win[2][2] <= pix_q;
      end
    end
  end

  // Positive and negative kernel halves, zero-extended to the gradient width.
  always_comb begin
    gx_pos = GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]);
    gx_neg = GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]);
    gy_pos = GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]);
    gy_neg = GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]);
  end

  // S2: register signed Gx and Gy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      v2   <= v1;
      gx_q <= signed'(gx_pos - gx_neg);
      gy_q <= signed'(gy_pos - gy_neg);
    end
  end

  // Magnitude, saturation and strict threshold compare.
  always_comb begin
    ax       = gx_q[GW-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
    ay       = gy_q[GW-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
    mag      = ax + ay;
    mag_sat  = (mag > GW'(SAT_LIMIT)) ? DATA_W'(SAT_LIMIT) : mag[DATA_W-1:0];
    edge_hit = mag_sat > threshold;
  end

  // S3: output register, one-cycle dout_valid pulse per interior pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      dout_valid <= v2;
      if (v2) begin
`ifdef SOBEL_MAG_OUT_EN
        dout <= edge_hit ? mag_sat : '0;
`else
        dout <= edge_hit ? '1 : '0;
`endif
      end
    end
  end

endmodule
